// File: rtl/inst_data_sram_arbiter_pkg.sv
// Shared definitions for the instruction/data SRAM arbiter.
package inst_data_sram_arbiter_pkg;

   localparam int WEN_W = 4;

   // Which port owns the access whose response returns next cycle.
   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_INST = 2'd1,
      OWN_DATA = 2'd2
   } owner_e;

endpackage

// File: rtl/inst_data_sram_arbiter_pick.sv
// Grant decision between IF and MEM requesters with a starvation guard:
// data normally wins, but after STARVE_LIMIT consecutive data grants with
// a fetch waiting, the fetch is forced through for one cycle.
module sram_arb_pick #(
   parameter int STARVE_LIMIT = 4
) (
   input  logic clk_i,
   input  logic reset_i,
   input  logic inst_req_i,
   input  logic data_req_i,
   output logic inst_gnt_o,
   output logic data_gnt_o
);

   localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
   localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

   logic [CNT_W-1:0] streak_q, streak_d;
   logic             at_limit;

   assign at_limit = (streak_q == LIMIT);

   // Grant decision; requests seen during reset are ignored.
   always_comb begin
      inst_gnt_o = 1'b0;
      data_gnt_o = 1'b0;
      if (!reset_i) begin
         inst_gnt_o = inst_req_i && (!data_req_i || at_limit);
         data_gnt_o = data_req_i && !inst_gnt_o;
      end
   end

   // Count data grants that overtook a waiting fetch, saturating at the limit.
   always_comb begin
      streak_d = streak_q;
      if (!inst_req_i || inst_gnt_o) begin
         streak_d = '0;
      end else if (data_gnt_o && !at_limit) begin
         streak_d = streak_q + 1'b1;
      end
   end

   // Streak register.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         streak_q <= '0;
      end else begin
         streak_q <= streak_d;
      end
   end

endmodule

// File: rtl/inst_data_sram_arbiter.sv
// Shares one single-port synchronous SRAM between instruction fetch and
// data access. One access per cycle, fixed one-cycle read latency, each
// response routed back to the port that issued it.
//
// Owner register (response routing for the access granted last cycle):
//   state    | meaning
//   OWN_NONE | no access outstanding, no response this cycle
//   OWN_INST | fetch outstanding, response goes to the IF port
//   OWN_DATA | data access outstanding, response goes to the MEM port
module inst_data_sram_arbiter
   import inst_data_sram_arbiter_pkg::*;
#(
   parameter int ADDR_W       = 32,
   parameter int DATA_W       = 32,
   parameter int STARVE_LIMIT = 4
) (
   input  logic              clk_i,
   input  logic              reset_i,
   input  logic              inst_req_i,
   input  logic [ADDR_W-1:0] inst_addr_i,
   input  logic              inst_cancel_i,
   output logic              inst_addr_ok_o,
   output logic              inst_data_ok_o,
   output logic [DATA_W-1:0] inst_rdata_o,
   input  logic              data_req_i,
   input  logic [WEN_W-1:0]  data_wen_i,
   input  logic [ADDR_W-1:0] data_addr_i,
   input  logic [DATA_W-1:0] data_wdata_i,
   output logic              data_addr_ok_o,
   output logic              data_data_ok_o,
   output logic [DATA_W-1:0] data_rdata_o,
   output logic              mem_en_o,
   output logic [WEN_W-1:0]  mem_wen_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [DATA_W-1:0] mem_wdata_o,
   input  logic [DATA_W-1:0] mem_rdata_i
);

   logic              inst_gnt, data_gnt;
   owner_e            owner_q, owner_d;
   logic [DATA_W-1:0] inst_hold_q, data_hold_q;

   sram_arb_pick #(
      .STARVE_LIMIT (STARVE_LIMIT)
   ) u_pick (
      .clk_i      (clk_i),
      .reset_i    (reset_i),
      .inst_req_i (inst_req_i),
      .data_req_i (data_req_i),
      .inst_gnt_o (inst_gnt),
      .data_gnt_o (data_gnt)
   );

   assign inst_addr_ok_o = inst_gnt;
   assign data_addr_ok_o = data_gnt;

   // Steer the granted port onto the memory; idle cycles drive zeros.
   always_comb begin
      mem_en_o    = inst_gnt | data_gnt;
      mem_wen_o   = '0;
      mem_addr_o  = '0;
      mem_wdata_o = '0;
      if (data_gnt) begin
         mem_wen_o   = data_wen_i;
         mem_addr_o  = data_addr_i;
         mem_wdata_o = data_wdata_i;
      end else if (inst_gnt) begin
         mem_addr_o  = inst_addr_i;
      end
   end

   // Next owner is simply this cycle's grant.
   always_comb begin
      owner_d = OWN_NONE;
      if (inst_gnt) begin
         owner_d = OWN_INST;
      end else if (data_gnt) begin
         owner_d = OWN_DATA;
      end
   end

   // Owner register; reset drops any outstanding response.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         owner_q <= OWN_NONE;
      end else begin
         owner_q <= owner_d;
      end
   end

   // Response routing; a cancelled fetch response is swallowed.
   always_comb begin
      data_data_ok_o = !reset_i && (owner_q == OWN_DATA);
      inst_data_ok_o = !reset_i && (owner_q == OWN_INST) && !inst_cancel_i;
      data_rdata_o   = data_data_ok_o ? mem_rdata_i : data_hold_q;
      inst_rdata_o   = inst_data_ok_o ? mem_rdata_i : inst_hold_q;
   end

   // Hold registers keep each port's last response stable until the next one.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         inst_hold_q <= '0;
         data_hold_q <= '0;
      end else begin
         if (inst_data_ok_o) begin
            inst_hold_q <= mem_rdata_i;
         end
         if (data_data_ok_o) begin
            data_hold_q <= mem_rdata_i;
         end
      end
   end

endmodule

// File: tb/tb_inst_data_sram_arbiter.sv
// Bench for inst_data_sram_arbiter: a small SRAM environment plus a
// transaction-level reference model checked every cycle.
module tb_inst_data_sram_arbiter;

   localparam int SL = 4;

   logic        clk_i = 1'b0;
   logic        reset_i;
   logic        inst_req_i, inst_cancel_i;
   logic [31:0] inst_addr_i;
   logic        inst_addr_ok_o, inst_data_ok_o;
   logic [31:0] inst_rdata_o;
   logic        data_req_i;
   logic [3:0]  data_wen_i;
   logic [31:0] data_addr_i, data_wdata_i;
   logic        data_addr_ok_o, data_data_ok_o;
   logic [31:0] data_rdata_o;
   logic        mem_en_o;
   logic [3:0]  mem_wen_o;
   logic [31:0] mem_addr_o, mem_wdata_o;
   logic [31:0] mem_rdata_i;

   int checks = 0;
   int errors = 0;

   inst_data_sram_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(SL)) dut (
      .clk_i          (clk_i),
      .reset_i        (reset_i),
      .inst_req_i     (inst_req_i),
      .inst_addr_i    (inst_addr_i),
      .inst_cancel_i  (inst_cancel_i),
      .inst_addr_ok_o (inst_addr_ok_o),
      .inst_data_ok_o (inst_data_ok_o),
      .inst_rdata_o   (inst_rdata_o),
      .data_req_i     (data_req_i),
      .data_wen_i     (data_wen_i),
      .data_addr_i    (data_addr_i),
      .data_wdata_i   (data_wdata_i),
      .data_addr_ok_o (data_addr_ok_o),
      .data_data_ok_o (data_data_ok_o),
      .data_rdata_o   (data_rdata_o),
      .mem_en_o       (mem_en_o),
      .mem_wen_o      (mem_wen_o),
      .mem_addr_o     (mem_addr_o),
      .mem_wdata_o    (mem_wdata_o),
      .mem_rdata_i    (mem_rdata_i)
   );

   always #5 clk_i = ~clk_i;

   function automatic logic [31:0] init_word(input int i);
      if (i == 0) return 32'h1234_5678;
      return 32'h0bad_0000 + 32'(i) * 32'h0101_0101;
   endfunction

   // SRAM environment: 64 words indexed by addr[7:2], read-before-write,
   // read data valid the cycle after the enable.
   logic [31:0] sram [64];
   initial begin
      int unsigned idx;
      for (int i = 0; i < 64; i++) sram[i] = init_word(i);
      mem_rdata_i = '0;
      forever begin
         @(posedge clk_i);
         if (mem_en_o) begin
            idx = 32'(mem_addr_o[7:2]);
            mem_rdata_i <= sram[idx];
            for (int b = 0; b < 4; b++)
               if (mem_wen_o[b]) sram[idx][8*b +: 8] = mem_wdata_o[8*b +: 8];
         end
      end
   end

   // Reference model state (transaction level).
   logic [31:0] mmem [64];
   int          m_streak;
   int          m_pend;      // 0 none, 1 fetch, 2 data
   logic        m_pend_wr;
   logic [31:0] m_pend_val, m_ihold, m_dhold;
   logic        e_ig, e_dg;

   // Sampled DUT outputs of the last step, for directed literal checks.
   logic        s_iaok, s_daok, s_idok, s_ddok, s_men;
   logic [31:0] s_maddr, s_irdata, s_drdata;
   logic [3:0]  s_mwen;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
      end
   endtask

   // Compare one cycle against the model, advance the model, move to next cycle.
   task automatic step();
      logic        e_men, e_idok, e_ddok;
      logic [31:0] e_maddr, e_mwdata;
      logic [3:0]  e_mwen;
      int unsigned idx;
      #3;
      s_iaok = inst_addr_ok_o; s_daok = data_addr_ok_o;
      s_idok = inst_data_ok_o; s_ddok = data_data_ok_o;
      s_men = mem_en_o; s_maddr = mem_addr_o; s_mwen = mem_wen_o;
      s_irdata = inst_rdata_o; s_drdata = data_rdata_o;
      if (reset_i) begin
         e_ig = 1'b0; e_dg = 1'b0;
         chk("rst_inst_addr_ok", 32'(inst_addr_ok_o), 0);
         chk("rst_data_addr_ok", 32'(data_addr_ok_o), 0);
         chk("rst_inst_data_ok", 32'(inst_data_ok_o), 0);
         chk("rst_data_data_ok", 32'(data_data_ok_o), 0);
         chk("rst_mem_en", 32'(mem_en_o), 0);
         m_streak = 0; m_pend = 0; m_ihold = '0; m_dhold = '0;
      end else begin
         e_ig = inst_req_i && (!data_req_i || m_streak == SL);
         e_dg = data_req_i && !e_ig;
         e_men = e_ig || e_dg;
         e_maddr = e_ig ? inst_addr_i : data_addr_i;
         e_mwen = e_dg ? data_wen_i : 4'h0;
         e_mwdata = e_dg ? data_wdata_i : 32'h0;
         e_idok = (m_pend == 1) && !inst_cancel_i;
         e_ddok = (m_pend == 2);
         chk("inst_addr_ok", 32'(inst_addr_ok_o), 32'(e_ig));
         chk("data_addr_ok", 32'(data_addr_ok_o), 32'(e_dg));
         chk("mem_en", 32'(mem_en_o), 32'(e_men));
         chk("inst_data_ok", 32'(inst_data_ok_o), 32'(e_idok));
         chk("data_data_ok", 32'(data_data_ok_o), 32'(e_ddok));
         if (e_men) begin
            chk("mem_addr", mem_addr_o, e_maddr);
            chk("mem_wen", 32'(mem_wen_o), 32'(e_mwen));
            chk("mem_wdata", mem_wdata_o, e_mwdata);
         end
         chk("inst_rdata", inst_rdata_o, e_idok ? m_pend_val : m_ihold);
         if (!e_ddok) chk("data_rdata_hold", data_rdata_o, m_dhold);
         else if (!m_pend_wr) chk("data_rdata", data_rdata_o, m_pend_val);
         if (e_idok) m_ihold = m_pend_val;
         if (e_ddok) m_dhold = m_pend_val;
         if (!inst_req_i || e_ig) m_streak = 0;
         else if (e_dg && m_streak < SL) m_streak++;
         m_pend = e_ig ? 1 : (e_dg ? 2 : 0);
         if (e_men) begin
            idx = 32'(e_maddr[7:2]);
            m_pend_val = mmem[idx];
            m_pend_wr = (e_mwen != 4'h0);
            for (int b = 0; b < 4; b++)
               if (e_mwen[b]) mmem[idx][8*b +: 8] = e_mwdata[8*b +: 8];
         end
      end
      @(posedge clk_i);
      #1;
   endtask

   task automatic idle_inputs();
      inst_req_i = 0; inst_addr_i = '0; inst_cancel_i = 0;
      data_req_i = 0; data_wen_i = '0; data_addr_i = '0; data_wdata_i = '0;
   endtask

   initial begin
      logic [9:0]  pat;
      int          nok;
      logic [31:0] prev;
      for (int i = 0; i < 64; i++) mmem[i] = init_word(i);
      m_streak = 0; m_pend = 0; m_pend_wr = 0;
      m_pend_val = '0; m_ihold = '0; m_dhold = '0;
      idle_inputs();
      reset_i = 1;
      inst_req_i = 1; data_req_i = 1;   // must be ignored during reset
      @(posedge clk_i);
      #1;
      step();
      step();
      reset_i = 0;
      idle_inputs();
      step();
      chk("reset_inst_rdata_zero", s_irdata, 32'h0);
      chk("reset_data_rdata_zero", s_drdata, 32'h0);

      // Single fetch from the boot vector.
      inst_req_i = 1; inst_addr_i = 32'hbfc0_0000;
      step();
      chk("boot_mem_en", 32'(s_men), 1);
      chk("boot_mem_addr", s_maddr, 32'hbfc0_0000);
      inst_req_i = 0;
      step();
      chk("boot_inst_data_ok", 32'(s_idok), 1);
      chk("boot_inst_rdata", s_irdata, 32'h1234_5678);
      step();
      chk("boot_rdata_held", s_irdata, 32'h1234_5678);

      // Both requesting continuously: D,D,D,D,I repeating.
      inst_req_i = 1; inst_addr_i = 32'h40;
      data_req_i = 1; data_addr_i = 32'h80;
      for (int i = 0; i < 10; i++) begin
         step();
         pat[i] = s_iaok;
      end
      chk("starve_pattern", 32'(pat), 32'(10'b10000_10000));
      idle_inputs();
      step();

      // Write then read back.
      data_req_i = 1; data_wen_i = 4'hf; data_addr_i = 32'h1000; data_wdata_i = 32'hdead_beef;
      step();
      chk("wr_mem_wen", 32'(s_mwen), 32'hf);
      data_wen_i = 4'h0; data_wdata_i = '0;
      step();
      chk("wr_data_ok", 32'(s_ddok), 1);
      data_req_i = 0;
      step();
      chk("rd_after_wr_ok", 32'(s_ddok), 1);
      chk("rd_after_wr_data", s_drdata, 32'hdead_beef);

      // Cancelled fetch response, with a new fetch granted in the same cycle.
      step();
      prev = s_irdata;
      inst_req_i = 1; inst_addr_i = 32'h44;
      step();
      inst_addr_i = 32'h48; inst_cancel_i = 1;
      step();
      chk("cancel_no_data_ok", 32'(s_idok), 0);
      chk("cancel_rdata_unchanged", s_irdata, prev);
      chk("cancel_new_grant", 32'(s_iaok), 1);
      inst_req_i = 0; inst_cancel_i = 0;
      step();
      chk("after_cancel_data_ok", 32'(s_idok), 1);
      chk("after_cancel_rdata", s_irdata, init_word(18));

      // Reset while a data access is outstanding.
      data_req_i = 1; data_addr_i = 32'h20;
      step();
      data_req_i = 0; reset_i = 1;
      step();
      chk("rst_drop_data_ok", 32'(s_ddok), 0);
      chk("rst_drop_mem_en", 32'(s_men), 0);
      reset_i = 0;
      step();
      chk("post_rst_data_ok", 32'(s_ddok), 0);
      chk("post_rst_data_rdata", s_drdata, 32'h0);

      // Alternating single-port reads: one response per cycle, no bubbles.
      nok = 0;
      for (int i = 0; i < 8; i++) begin
         inst_req_i = (i % 2 == 0); inst_addr_i = 32'(i * 4);
         data_req_i = (i % 2 == 1); data_addr_i = 32'(i * 4 + 64);
         step();
         nok += int'(s_idok) + int'(s_ddok);
      end
      idle_inputs();
      step();
      nok += int'(s_idok) + int'(s_ddok);
      chk("alternating_responses", 32'(nok), 32'd8);

      // Randomized traffic obeying the hold-until-granted protocol.
      for (int c = 0; c < 1500; c++) begin
         reset_i = ($urandom_range(0, 99) == 0);
         inst_cancel_i = ($urandom_range(0, 3) == 0);
         if (inst_req_i && e_ig) inst_req_i = 0;
         if (data_req_i && e_dg) data_req_i = 0;
         if (!inst_req_i && $urandom_range(0, 2) != 0) begin
            inst_req_i = 1;
            inst_addr_i = {20'h0, 4'($urandom), 6'($urandom), 2'b00};
         end
         if (!data_req_i && $urandom_range(0, 2) != 0) begin
            data_req_i = 1;
            data_wen_i = $urandom_range(0, 1) ? 4'($urandom) : 4'h0;
            data_addr_i = {20'h0, 4'($urandom), 6'($urandom), 2'b00};
            data_wdata_i = $urandom;
         end
         step();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/inst_data_sram_arbiter.md
# inst_data_sram_arbiter

Shares one synchronous single-port SRAM between the IF-stage instruction fetch port and the MEM-stage data port of the 5-stage CPU. Grants at most one access per cycle, prioritising data over instruction fetch, with an anti-starvation limit so IF always makes progress. Read data returns with a fixed one-cycle latency and is routed to the owner of each access. Sits between the pipeline stages and the single external memory port.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width
- STARVE_LIMIT, 4, consecutive data grants allowed while an inst request waits (must be ≥1)

- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- inst_req  in  1  IF requests a fetch this cycle
- inst_addr  in  ADDR_W  fetch address
- inst_cancel  in  1  discard the fetch response arriving this cycle (branch redirect)
- inst_addr_ok  out  1  fetch granted this cycle
- inst_data_ok  out  1  fetch response valid this cycle
- inst_rdata  out  DATA_W  fetch data, held stable between responses
- data_req  in  1  MEM requests an access
- data_wen  in  4  byte write enables, 0 = read
- data_addr  in  ADDR_W  access address
- data_wdata  in  DATA_W  write data
- data_addr_ok  out  1  data access granted this cycle
- data_data_ok  out  1  data response valid (read data or write completion)
- data_rdata  out  DATA_W  read data, held stable between responses
- mem_en  out  1  memory enable
- mem_wen  out  4  memory byte write enables
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, valid the cycle after mem_en

## Operation
- Grant (combinational, same cycle as request):
  - Data wins unless inst_req=1 and streak==STARVE_LIMIT; then inst wins.
  - Only one requester → it wins. Neither → mem_en=0.
- Granted port's addr/wen/wdata drive mem_*. Inst grant drives mem_wen=0 and mem_wdata=0. The matching addr_ok=1.
- Streak counter (0..STARVE_LIMIT):
  - +1 on a data grant while inst_req=1.
  - Cleared on an inst grant, or in any cycle with inst_req=0.
  - Saturates at STARVE_LIMIT.
- Owner register (FSM) states:
  - NONE, INST, DATA.
  - Loaded every cycle with the current grant (NONE if no grant).
- Response cycle (registered owner):
  - owner=DATA: data_data_ok=1 and data_rdata=mem_rdata. For writes, rdata content is don't-care, but the hold register still updates.
  - owner=INST and inst_cancel=0: inst_data_ok=1 and inst_rdata=mem_rdata.
  - owner=INST and inst_cancel=1: no inst_data_ok, and the inst hold register is unchanged.
- rdata outputs are mux(data_ok ? mem_rdata : hold_reg). Each hold register captures on its own data_ok, so rdata stays stable until the next response for that port.
- A new grant and the previous grant's response may occur in the same cycle, giving full back-to-back throughput.

## Timing
- Reset values:
  - owner=NONE, streak=0.
  - Both hold registers 0.
  - All *_addr_ok, *_data_ok and mem_en are 0 during the reset cycle. Requests in the reset cycle are ignored.
- Latency: addr_ok in cycle N → data_ok in cycle N+1, exactly. No buffering beyond one outstanding access.
- Requesters keep req/addr stable until addr_ok is seen. Responses cannot be back-pressured.
- Reset asserted while an access is outstanding: the response is dropped, and no data_ok follows the reset cycle.
- inst_cancel only has an effect in a response cycle with owner=INST. In all other cycles it is ignored.
- Simultaneous inst and data requests at the starvation limit: inst is granted, data waits exactly one cycle.

## Structure
- Shared package holds:
  - owner encoding: OWN_NONE=2'd0, OWN_INST=2'd1, OWN_DATA=2'd2
  - WEN_W=4
- One sub-module: sram_arb_pick, which contains the grant decision and the streak counter. Outputs are inst_gnt/data_gnt.
- Top level holds the mem_* mux, the owner register, response routing and the hold registers.

## Test plan
- Reset, then a single inst_req at 0xbfc00000 → mem_en=1 and mem_addr=0xbfc00000 in cycle N; inst_data_ok=1 with inst_rdata=mem_rdata in N+1; inst_rdata holds that value while idle.
- inst_req and data_req held continuously, STARVE_LIMIT=4 → grant pattern D,D,D,D,I repeating; inst_data_ok every 5th cycle.
- Data write: wen=4'hf, addr 0x1000, wdata 0xdeadbeef → mem_wen=4'hf in N; data_data_ok=1 in N+1; a following read of 0x1000 returns 0xdeadbeef.
- inst grant in N, inst_cancel=1 in N+1 → no inst_data_ok, inst_rdata unchanged. A new inst grant in N+1 responds in N+2.
- Reset asserted in the cycle after a data grant → no data_data_ok; all outputs 0; streak=0.
- Alternating read grants every cycle → one data_ok per cycle, each carrying the correct owner's data, with no bubbles.
